// File: rtl/n64_bus_master.sv
// n64_bus_master: device-bus initiator with single-outstanding requests, ack timeout and a sequential read-prefetch FIFO.
module n64_bus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pi_start,
  input  logic [31:0] pi_address,
  input  logic        pi_read,
  output logic [15:0] pi_rdata,
  output logic        pi_rvalid,
  input  logic        pi_write,
  input  logic [15:0] pi_wdata,
  output logic        pi_wbusy,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, bus_address_q;
  logic [15:0] mem_q [FIFO_DEPTH];
  logic [15:0] wdata_q, bus_wdata_q;
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic [TW-1:0] timer_q;
  logic burst_q, wpend_q, discard_q, err_q, bus_write_q;
  logic wr_acc, flush, issue, timed_out, done, push, pop;
  assign pi_wbusy = wpend_q || (state_q != S_IDLE && bus_write_q);
  assign wr_acc = pi_write && !pi_wbusy && !pi_start;
  assign flush = pi_start || wr_acc;
  assign issue = state_q == S_IDLE && !flush && (wpend_q || (burst_q && cnt_q < (AW+1)'(FIFO_DEPTH)));
  assign timed_out = state_q == S_WAIT && timer_q == TW'(TIMEOUT - 1);
  assign done = state_q == S_WAIT && (bus_ack || timed_out);
  assign push = done && !bus_write_q && !discard_q && !flush;
  assign pop = pi_read && cnt_q != '0 && !flush;
  always_comb begin
    state_d = state_q == S_IDLE ? (issue ? S_REQ : S_IDLE) :
              state_q == S_REQ  ? S_WAIT : (done ? S_IDLE : S_WAIT);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      bus_address_q <= '0;
      bus_wdata_q <= '0;
      bus_write_q <= 1'b0;
      wdata_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      timer_q <= '0;
      burst_q <= 1'b0;
      wpend_q <= 1'b0;
      discard_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= state_q == S_WAIT ? timer_q + 1'b1 : '0;
      if (pi_start) addr_q <= pi_address & 32'hFFFF_FFFE;
      else if (issue) addr_q <= addr_q + 32'd2;
      if (issue) begin
        bus_write_q <= wpend_q;
        bus_address_q <= addr_q;
        bus_wdata_q <= wdata_q;
      end
      if (wr_acc) wdata_q <= pi_wdata;
      wpend_q <= wr_acc || (wpend_q && !pi_start && !issue);
      burst_q <= pi_start || (burst_q && !wr_acc);
      // a request still on the bus when the burst is abandoned must not land in the new FIFO
      discard_q <= flush ? (state_q != S_IDLE && !done) : (done ? 1'b0 : discard_q);
      err_q <= !pi_start && (err_q || (timed_out && !bus_ack));
      wp_q <= flush ? '0 : wp_q + AW'(push);
      rp_q <= flush ? '0 : rp_q + AW'(pop);
      cnt_q <= flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus_ack ? bus_rdata : 16'h0000;
  end
  assign pi_rvalid = cnt_q != '0;
  assign pi_rdata = pi_rvalid ? mem_q[rp_q] : 16'h0000;
  assign bus_request = state_q == S_REQ;
  assign bus_write = bus_write_q;
  assign bus_address = bus_address_q;
  assign bus_wdata = bus_wdata_q;
  assign timeout_err = err_q;
endmodule
